// File: rtl/capture_sequencer.sv
// Capture sequencer: SPI op-code decode, frame-valid driven capture FSM with
// watchdog, crop window staging/commit and a status response byte.
module capture_sequencer #(
  parameter int X_MAX          = 1280,
  parameter int Y_MAX          = 720,
  parameter int TIMEOUT_CYCLES = 72000000
) (
  input  logic        clock_spi_in,
  input  logic        reset_spi_n_in,
  input  logic [7:0]  op_code_in,
  input  logic        op_code_valid_in,
  input  logic [7:0]  operand_in,
  input  logic        operand_valid_in,
  input  logic [31:0] operand_count_in,
  input  logic        frame_valid_in,
  output logic [10:0] x_crop_start_out,
  output logic [10:0] x_crop_end_out,
  output logic [9:0]  y_crop_start_out,
  output logic [9:0]  y_crop_end_out,
  output logic        buffer_clear_out,
  output logic        capture_active_out,
  output logic [7:0]  response_out,
  output logic        response_valid_out
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_SOF, ACTIVE} state_t;

  localparam logic [7:0]  OP_CAPTURE = 8'h20;
  localparam logic [7:0]  OP_CROP    = 8'h26;
  localparam logic [7:0]  OP_STATUS  = 8'h27;
  localparam logic [31:0] WD_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] X_LIMIT    = 12'(X_MAX);
  localparam logic [10:0] Y_LIMIT    = 11'(Y_MAX);

  state_t      state_q, state_d;
  logic        fv_meta, fv;
  logic        op_vld_q, opnd_vld_q;
  logic [7:0]  op_q;
  logic [31:0] wd_cnt;
  logic        done_q, timeout_q, overrun_q, crop_err_q;
  logic [10:0] xs_stg, xe_stg;
  logic [9:0]  ys_stg, ye_stg;

  logic        op_rise, op_fall, cap_req, cap_accept, wd_expire, done_set;
  logic        opnd_take, crop_evt, crop_ok, x_ok, y_ok, status_clr, status_req;
  logic [7:0]  op_cur, status_byte;

  // The latched op-code tracks the command for its whole valid window,
  // including the falling-edge actions.
  assign op_rise     = op_code_valid_in & ~op_vld_q;
  assign op_fall     = ~op_code_valid_in & op_vld_q;
  assign op_cur      = op_rise ? op_code_in : op_q;
  assign cap_req     = op_rise && (op_code_in == OP_CAPTURE);
  assign cap_accept  = cap_req && (state_q == IDLE);
  assign wd_expire   = (state_q != IDLE) && (wd_cnt == WD_LAST);
  assign done_set    = (state_q == ACTIVE) && !fv && !wd_expire;
  assign opnd_take   = operand_valid_in && !opnd_vld_q && op_code_valid_in &&
                       (op_cur == OP_CROP) && (operand_count_in < 32'd8);
  assign crop_evt    = op_fall && (op_q == OP_CROP);
  assign status_clr  = op_fall && (op_q == OP_STATUS);
  assign status_req  = op_code_valid_in && (op_cur == OP_STATUS);
  assign status_byte = {3'b000, crop_err_q, timeout_q, overrun_q, done_q,
                        state_q != IDLE};

  // One extra bit keeps start+4 from wrapping near the top of the range.
  assign x_ok    = ({1'b0, xe_stg} >= ({1'b0, xs_stg} + 12'd4)) &&
                   ({1'b0, xe_stg} <= X_LIMIT);
  assign y_ok    = ({1'b0, ye_stg} >= ({1'b0, ys_stg} + 11'd4)) &&
                   ({1'b0, ye_stg} <= Y_LIMIT);
  assign crop_ok = (state_q == IDLE) && x_ok && y_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cap_accept) state_d = ARM;
      ARM:      if (!fv)        state_d = WAIT_SOF;
      WAIT_SOF: if (fv)         state_d = ACTIVE;
      ACTIVE:   if (!fv)        state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
    if (wd_expire) state_d = IDLE;
    capture_active_out = (state_q == WAIT_SOF) || (state_q == ACTIVE);
  end

  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in) begin
      state_q    <= IDLE;
      fv_meta    <= 1'b0;
      fv         <= 1'b0;
      op_vld_q   <= 1'b0;
      opnd_vld_q <= 1'b0;
      op_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      fv_meta    <= frame_valid_in;
      fv         <= fv_meta;
      op_vld_q   <= op_code_valid_in;
      opnd_vld_q <= operand_valid_in;
      if (op_rise) op_q <= op_code_in;
    end
  end

  // Watchdog sits at zero in IDLE, so entry into ARM always starts from zero.
  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in)                   wd_cnt <= 32'd0;
    else if (state_q == IDLE || wd_expire) wd_cnt <= 32'd0;
    else                                   wd_cnt <= wd_cnt + 32'd1;
  end

  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in) begin
      done_q             <= 1'b0;
      timeout_q          <= 1'b0;
      overrun_q          <= 1'b0;
      crop_err_q         <= 1'b0;
      buffer_clear_out   <= 1'b0;
      response_valid_out <= 1'b0;
      response_out       <= 8'h00;
    end else begin
      if (cap_accept)    done_q <= 1'b0;
      else if (done_set) done_q <= 1'b1;
      // A new error event in the same cycle as a status clear is kept.
      if (status_clr) begin
        timeout_q  <= 1'b0;
        overrun_q  <= 1'b0;
        crop_err_q <= 1'b0;
      end
      if (wd_expire)                     timeout_q  <= 1'b1;
      if (cap_req && state_q != IDLE)    overrun_q  <= 1'b1;
      if (crop_evt && !crop_ok)          crop_err_q <= 1'b1;
      buffer_clear_out   <= cap_accept;
      response_valid_out <= status_req;
      response_out       <= status_req ? status_byte : 8'h00;
    end
  end

  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in) begin
      xs_stg <= 11'd0;
      xe_stg <= 11'd0;
      ys_stg <= 10'd0;
      ye_stg <= 10'd0;
    end else if (opnd_take) begin
      unique case (operand_count_in[2:0])
        3'd0: xs_stg[10:8] <= operand_in[2:0];
        3'd1: xs_stg[7:0]  <= operand_in;
        3'd2: xe_stg[10:8] <= operand_in[2:0];
        3'd3: xe_stg[7:0]  <= operand_in;
        3'd4: ys_stg[9:8]  <= operand_in[1:0];
        3'd5: ys_stg[7:0]  <= operand_in;
        3'd6: ye_stg[9:8]  <= operand_in[1:0];
        3'd7: ye_stg[7:0]  <= operand_in;
        default: ;
      endcase
    end
  end

  // Commit only happens in IDLE, so the window is frozen through a capture.
  always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
    if (!reset_spi_n_in) begin
      x_crop_start_out <= 11'd0;
      x_crop_end_out   <= 11'd18;
      y_crop_start_out <= 10'd0;
      y_crop_end_out   <= 10'd18;
    end else if (crop_evt && crop_ok) begin
      x_crop_start_out <= xs_stg;
      x_crop_end_out   <= xe_stg;
      y_crop_start_out <= ys_stg;
      y_crop_end_out   <= ye_stg;
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: crop vector table plus hand-written
// capture, overrun, timeout and reset sequences.
module tb_capture_sequencer;

  logic        clock_spi_in = 1'b0;
  logic        reset_spi_n_in = 1'b0;
  logic [7:0]  op_code_in = 8'h00;
  logic        op_code_valid_in = 1'b0;
  logic [7:0]  operand_in = 8'h00;
  logic        operand_valid_in = 1'b0;
  logic [31:0] operand_count_in = 32'd0;
  logic        frame_valid_in = 1'b0;
  logic [10:0] x_crop_start_out, x_crop_end_out;
  logic [9:0]  y_crop_start_out, y_crop_end_out;
  logic        buffer_clear_out, capture_active_out, response_valid_out;
  logic [7:0]  response_out;

  int vec_cnt = 0;
  int miscompares = 0;

  capture_sequencer #(.X_MAX(1280), .Y_MAX(720), .TIMEOUT_CYCLES(1000)) dut (
    .clock_spi_in(clock_spi_in), .reset_spi_n_in(reset_spi_n_in),
    .op_code_in(op_code_in), .op_code_valid_in(op_code_valid_in),
    .operand_in(operand_in), .operand_valid_in(operand_valid_in),
    .operand_count_in(operand_count_in), .frame_valid_in(frame_valid_in),
    .x_crop_start_out(x_crop_start_out), .x_crop_end_out(x_crop_end_out),
    .y_crop_start_out(y_crop_start_out), .y_crop_end_out(y_crop_end_out),
    .buffer_clear_out(buffer_clear_out), .capture_active_out(capture_active_out),
    .response_out(response_out), .response_valid_out(response_valid_out)
  );

  always #5 clock_spi_in = ~clock_spi_in;

  typedef struct {
    logic [63:0] opnds;
    logic [10:0] xs, xe;
    logic [9:0]  ys, ye;
    logic [7:0]  status;
  } crop_vec_t;

  crop_vec_t vecs [10];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock_spi_in);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] win();
    return {22'd0, x_crop_start_out, x_crop_end_out, y_crop_start_out, y_crop_end_out};
  endfunction

  function automatic logic [63:0] mkwin(input int xs, input int xe, input int ys, input int ye);
    return {22'd0, 11'(xs), 11'(xe), 10'(ys), 10'(ye)};
  endfunction

  task automatic read_status(input string nm, input logic [7:0] exp);
    op_code_in = 8'h27;
    op_code_valid_in = 1'b1;
    tick();
    chk({nm, "_rv"}, 64'(response_valid_out), 64'd1);
    chk(nm, 64'(response_out), 64'(exp));
    op_code_valid_in = 1'b0;
    tick();
    chk({nm, "_rv_low"}, 64'(response_valid_out), 64'd0);
  endtask

  task automatic send_capture(input string nm, input logic exp_clear);
    op_code_in = 8'h20;
    op_code_valid_in = 1'b1;
    tick();
    chk({nm, "_clr1"}, 64'(buffer_clear_out), 64'(exp_clear));
    op_code_valid_in = 1'b0;
    tick();
    chk({nm, "_clr2"}, 64'(buffer_clear_out), 64'd0);
  endtask

  task automatic send_crop(input logic [63:0] opnds);
    op_code_in = 8'h26;
    op_code_valid_in = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      operand_in = opnds[63-8*i -: 8];
      operand_count_in = 32'(i);
      operand_valid_in = 1'b1;
      tick();
      operand_valid_in = 1'b0;
      tick();
    end
    op_code_valid_in = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{64'h0000_0280_0000_00C8, 11'd0,   11'd640,  10'd0,  10'd200, 8'h00};
    vecs[1] = '{64'h0000_0502_0000_00C8, 11'd0,   11'd640,  10'd0,  10'd200, 8'h10};
    vecs[2] = '{64'h0100_0104_0010_0020, 11'd256, 11'd260,  10'd16, 10'd32,  8'h00};
    vecs[3] = '{64'h0100_0103_0010_0020, 11'd256, 11'd260,  10'd16, 10'd32,  8'h10};
    vecs[4] = '{64'h0000_0500_0000_02D0, 11'd0,   11'd1280, 10'd0,  10'd720, 8'h00};
    vecs[5] = '{64'h0000_0500_0000_02D1, 11'd0,   11'd1280, 10'd0,  10'd720, 8'h10};
    vecs[6] = '{64'hF800_FA00_FC05_FD00, 11'd0,   11'd512,  10'd5,  10'd256, 8'h00};
    vecs[7] = '{64'h07FF_0003_0000_0010, 11'd0,   11'd512,  10'd5,  10'd256, 8'h10};
    vecs[8] = '{64'h0000_0400_03FF_0003, 11'd0,   11'd512,  10'd5,  10'd256, 8'h10};
    vecs[9] = '{64'h0000_0280_0000_00C8, 11'd0,   11'd640,  10'd0,  10'd200, 8'h00};

    // Reset state
    tick(3);
    chk("rst_win", win(), mkwin(0, 18, 0, 18));
    chk("rst_active", 64'(capture_active_out), 64'd0);
    chk("rst_clear", 64'(buffer_clear_out), 64'd0);
    chk("rst_resp", {55'd0, response_valid_out, response_out}, 64'd0);
    reset_spi_n_in = 1'b1;
    tick(2);
    read_status("rst_status", 8'h00);

    // Crop table
    for (int i = 0; i < 10; i++) begin
      send_crop(vecs[i].opnds);
      chk($sformatf("crop%0d_win", i), win(),
          {22'd0, vecs[i].xs, vecs[i].xe, vecs[i].ys, vecs[i].ye});
      read_status($sformatf("crop%0d_status", i), vecs[i].status);
    end

    // Operand counts above 7 are dropped; staging still holds the last window
    op_code_in = 8'h26;
    op_code_valid_in = 1'b1;
    tick();
    operand_in = 8'h07; operand_count_in = 32'd8; operand_valid_in = 1'b1; tick();
    operand_valid_in = 1'b0; tick();
    operand_in = 8'hFF; operand_count_in = 32'd9; operand_valid_in = 1'b1; tick();
    operand_valid_in = 1'b0; tick();
    op_code_valid_in = 1'b0;
    tick();
    chk("cnt8_win", win(), mkwin(0, 640, 0, 200));
    read_status("cnt8_status", 8'h00);

    // Basic capture with a 100-cycle frame
    frame_valid_in = 1'b0;
    send_capture("capA", 1'b1);
    tick(2);
    chk("capA_wait_sof", 64'(capture_active_out), 64'd1);
    frame_valid_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("capA_active", 64'(capture_active_out), 64'd1);
    end
    frame_valid_in = 1'b0;
    tick(5);
    chk("capA_idle", 64'(capture_active_out), 64'd0);
    read_status("capA_status", 8'h02);

    // Capture request during ACTIVE, crop while busy
    send_capture("capB", 1'b1);
    tick(3);
    frame_valid_in = 1'b1;
    tick(5);
    send_capture("capB_overrun", 1'b0);
    read_status("capB_status1", 8'h05);
    read_status("capB_status2", 8'h01);
    send_crop(vecs[2].opnds);
    chk("busy_crop_win", win(), mkwin(0, 640, 0, 200));
    read_status("busy_crop_status", 8'h11);
    frame_valid_in = 1'b0;
    tick(5);
    read_status("capB_done", 8'h02);

    // Frame already valid at arm time: must wait for the next frame start
    frame_valid_in = 1'b1;
    tick(3);
    send_capture("capC", 1'b1);
    tick(10);
    chk("capC_arm_hold", 64'(capture_active_out), 64'd0);
    frame_valid_in = 1'b0;
    tick(4);
    chk("capC_wait_sof", 64'(capture_active_out), 64'd1);
    frame_valid_in = 1'b1;
    tick(4);
    chk("capC_active", 64'(capture_active_out), 64'd1);
    frame_valid_in = 1'b0;
    tick(5);
    chk("capC_idle", 64'(capture_active_out), 64'd0);
    read_status("capC_status", 8'h02);

    // Unknown op-code: no response, no state change
    op_code_in = 8'h55;
    op_code_valid_in = 1'b1;
    tick();
    chk("unk_rv1", 64'(response_valid_out), 64'd0);
    tick();
    chk("unk_rv2", 64'(response_valid_out), 64'd0);
    op_code_valid_in = 1'b0;
    tick();
    read_status("unk_status", 8'h02);

    // Watchdog timeout with frame valid stuck low
    send_capture("capD", 1'b1);
    tick(990);
    chk("capD_before_to", 64'(capture_active_out), 64'd1);
    tick(20);
    chk("capD_after_to", 64'(capture_active_out), 64'd0);
    read_status("capD_status", 8'h08);
    read_status("capD_status2", 8'h00);

    // Asynchronous reset during ACTIVE
    send_capture("capE", 1'b1);
    tick(3);
    frame_valid_in = 1'b1;
    tick(5);
    chk("capE_active", 64'(capture_active_out), 64'd1);
    send_capture("capE_overrun", 1'b0);
    #2;
    reset_spi_n_in = 1'b0;
    #1;
    chk("capE_rst_active", 64'(capture_active_out), 64'd0);
    chk("capE_rst_win", win(), mkwin(0, 18, 0, 18));
    chk("capE_rst_resp", {55'd0, response_valid_out, response_out}, 64'd0);
    tick(2);
    reset_spi_n_in = 1'b1;
    frame_valid_in = 1'b0;
    tick();
    chk("capE_post_clear", 64'(buffer_clear_out), 64'd0);
    tick(3);
    chk("capE_post_active", 64'(capture_active_out), 64'd0);
    read_status("capE_status", 8'h00);

    // Reset landing on the clear pulse
    op_code_in = 8'h20;
    op_code_valid_in = 1'b1;
    tick();
    chk("capF_clr", 64'(buffer_clear_out), 64'd1);
    #2;
    reset_spi_n_in = 1'b0;
    #1;
    chk("capF_rst_clr", 64'(buffer_clear_out), 64'd0);
    op_code_valid_in = 1'b0;
    tick(2);
    reset_spi_n_in = 1'b1;
    tick(2);
    chk("capF_post_clear", 64'(buffer_clear_out), 64'd0);
    read_status("capF_status", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
